// File: rtl/video_timing_gen_if.sv
// Fetch-side coordinates/strobes and panel sync outputs of video_timing_gen, plus its run enable.
interface video_timing_gen_if #(
    parameter int COORD_W = 10,
    parameter int FRAME_W = 8
);
    logic               en;
    logic [COORD_W-1:0] h_pos;
    logic [COORD_W-1:0] v_pos;
    logic               valid_draw;
    logic               v_blank;
    logic               frame_start;
    logic               line_start;
    logic               vblank_start;
    logic [FRAME_W-1:0] frame_count;
    logic               disp_hsync;
    logic               disp_vsync;
    logic               disp_de;

    modport master (
        input  en,
        output h_pos, v_pos, valid_draw, v_blank, frame_start, line_start,
               vblank_start, frame_count, disp_hsync, disp_vsync, disp_de
    );

    modport slave (
        output en,
        input  h_pos, v_pos, valid_draw, v_blank, frame_start, line_start,
               vblank_start, frame_count, disp_hsync, disp_vsync, disp_de
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised pixel position / sync generator; panel sync and DE lag the fetch side by LOOKAHEAD cycles.
// state    | meaning
// ST_IDLE  | not running: counters held at 0, all fetch outputs inactive
// ST_RUN   | running: counters sweep the frame, decodes active
module video_timing_gen #(
    parameter int COORD_W   = 10,
    parameter int H_ACTIVE  = 480,
    parameter int H_FRONT   = 2,
    parameter int H_SYNC    = 41,
    parameter int H_BACK    = 2,
    parameter int V_ACTIVE  = 272,
    parameter int V_FRONT   = 2,
    parameter int V_SYNC    = 10,
    parameter int V_BACK    = 2,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int LOOKAHEAD = 2,
    parameter int FRAME_W   = 8
) (
    input logic clk,
    input logic reset,
    video_timing_gen_if.master vt
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;

    localparam logic [COORD_W-1:0] H_LAST_C   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST_C   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG_C   = COORD_W'(HS_BEG);
    localparam logic [COORD_W-1:0] HS_END_C   = COORD_W'(HS_BEG + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG_C   = COORD_W'(VS_BEG);
    localparam logic [COORD_W-1:0] VS_END_C   = COORD_W'(VS_BEG + V_SYNC);
    localparam logic               HS_ACT     = (HSYNC_POL != 0);
    localparam logic               VS_ACT     = (VSYNC_POL != 0);

    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            LOOKAHEAD < 0 || LOOKAHEAD > 7 || COORD_W < 1 || COORD_W > 30 ||
            FRAME_W < 1 || (H_TOTAL - 1) >= (1 << COORD_W) ||
            (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_param_err
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state, state_nxt;
    logic               running;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               de_raw, hs_raw, vs_raw;
    logic               de_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        if (vt.en) state_nxt = ST_RUN;
    end

    assign running = (state == ST_RUN);

    // Dropping en zeroes the counters on the same edge that stops running.
    always_ff @(posedge clk) begin
        if (reset || !vt.en || !running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST_C) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign de_raw = running && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_raw = running && (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    assign vs_raw = running && (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);

    assign vt.h_pos        = h_cnt;
    assign vt.v_pos        = v_cnt;
    assign vt.valid_draw   = de_raw;
    assign vt.v_blank      = running && (v_cnt >= V_ACT_C);
    assign vt.line_start   = running && (h_cnt == '0);
    assign vt.frame_start  = running && (h_cnt == '0) && (v_cnt == '0);
    assign vt.vblank_start = running && (h_cnt == '0) && (v_cnt == V_ACT_C);
    assign vt.frame_count  = frame_cnt;

    always_ff @(posedge clk) begin
        if (reset)               frame_cnt <= '0;
        else if (vt.frame_start) frame_cnt <= frame_cnt + 1'b1;
    end

    // Delay stages hold active-high raw flags; 0 is the inactive fill value.
    generate
        if (LOOKAHEAD == 0) begin : g_nodly
            assign de_q = de_raw;
            assign hs_q = hs_raw;
            assign vs_q = vs_raw;
        end else begin : g_dly
            logic [LOOKAHEAD-1:0] de_sr, hs_sr, vs_sr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    de_sr <= '0;
                    hs_sr <= '0;
                    vs_sr <= '0;
                end else begin
                    de_sr[0] <= de_raw;
                    hs_sr[0] <= hs_raw;
                    vs_sr[0] <= vs_raw;
                    for (int i = 1; i < LOOKAHEAD; i++) begin
                        de_sr[i] <= de_sr[i-1];
                        hs_sr[i] <= hs_sr[i-1];
                        vs_sr[i] <= vs_sr[i-1];
                    end
                end
            end

            assign de_q = de_sr[LOOKAHEAD-1];
            assign hs_q = hs_sr[LOOKAHEAD-1];
            assign vs_q = vs_sr[LOOKAHEAD-1];
        end
    endgenerate

    assign vt.disp_de    = de_q;
    assign vt.disp_hsync = HS_ACT ? hs_q : ~hs_q;
    assign vt.disp_vsync = VS_ACT ? vs_q : ~vs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on an 8x6 total raster, LOOKAHEAD 2 plus a LOOKAHEAD 0 / hsync-high instance.
module tb_video_timing_gen;

    logic clk;
    logic reset;
    logic en;
    int   n_chk;
    int   n_bad;

    video_timing_gen_if #(.COORD_W(4), .FRAME_W(2)) bus_a ();
    video_timing_gen_if #(.COORD_W(4), .FRAME_W(2)) bus_b ();

    assign bus_a.en = en;
    assign bus_b.en = en;

    video_timing_gen #(
        .COORD_W(4), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .LOOKAHEAD(2), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .vt(bus_a)
    );

    video_timing_gen #(
        .COORD_W(4), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .LOOKAHEAD(0), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .vt(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eh(int i);  return i % 8;        endfunction
    function automatic int ev(int i);  return (i / 8) % 6;  endfunction
    function automatic bit evd(int i); return (eh(i) < 4) && (ev(i) < 3); endfunction
    function automatic bit ehs(int i); return (eh(i) == 5) || (eh(i) == 6); endfunction
    function automatic bit evs(int i); return ev(i) == 4; endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".h_pos"},       32'(bus_a.h_pos), 0);
        chk({tag, ".v_pos"},       32'(bus_a.v_pos), 0);
        chk({tag, ".valid_draw"},  32'(bus_a.valid_draw), 0);
        chk({tag, ".frame_start"}, 32'(bus_a.frame_start), 0);
        chk({tag, ".disp_hsync"},  32'(bus_a.disp_hsync), 1);
        chk({tag, ".disp_vsync"},  32'(bus_a.disp_vsync), 1);
    endtask

    initial begin
        int n_vb, n_vsl, n_vbs, n_fs, exp_fc;
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        en    = 1'b0;

        // reset held with en low
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle($sformatf("rst%0d", k));
            chk($sformatf("rst%0d.disp_de", k),     32'(bus_a.disp_de), 0);
            chk($sformatf("rst%0d.frame_count", k), 32'(bus_a.frame_count), 0);
            chk($sformatf("rst%0d.v_blank", k),     32'(bus_a.v_blank), 0);
        end
        reset = 1'b0;
        tick();
        chk_idle("idle");
        chk("idle.line_start", 32'(bus_a.line_start), 0);

        // five full frames from enable
        en = 1'b1;
        tick();
        n_vb = 0; n_vsl = 0; n_vbs = 0; n_fs = 0;
        for (int i = 0; i < 240; i++) begin
            exp_fc = (i == 0) ? 0 : (((i - 1) / 48 + 1) % 4);
            chk($sformatf("h_pos@%0d", i),        32'(bus_a.h_pos), 32'(eh(i)));
            chk($sformatf("v_pos@%0d", i),        32'(bus_a.v_pos), 32'(ev(i)));
            chk($sformatf("valid_draw@%0d", i),   32'(bus_a.valid_draw), 32'(evd(i)));
            chk($sformatf("v_blank@%0d", i),      32'(bus_a.v_blank), 32'(ev(i) >= 3));
            chk($sformatf("frame_start@%0d", i),  32'(bus_a.frame_start), 32'(eh(i) == 0 && ev(i) == 0));
            chk($sformatf("line_start@%0d", i),   32'(bus_a.line_start), 32'(eh(i) == 0));
            chk($sformatf("vblank_start@%0d", i), 32'(bus_a.vblank_start), 32'(eh(i) == 0 && ev(i) == 3));
            chk($sformatf("frame_count@%0d", i),  32'(bus_a.frame_count), 32'(exp_fc));
            chk($sformatf("disp_de@%0d", i),      32'(bus_a.disp_de), (i >= 2) ? 32'(evd(i - 2)) : 0);
            chk($sformatf("disp_hsync@%0d", i),   32'(bus_a.disp_hsync), (i >= 2) ? 32'(!ehs(i - 2)) : 1);
            chk($sformatf("disp_vsync@%0d", i),   32'(bus_a.disp_vsync), (i >= 2) ? 32'(!evs(i - 2)) : 1);
            chk($sformatf("b.disp_de@%0d", i),    32'(bus_b.disp_de), 32'(evd(i)));
            chk($sformatf("b.disp_hsync@%0d", i), 32'(bus_b.disp_hsync), 32'(ehs(i)));
            chk($sformatf("b.disp_vsync@%0d", i), 32'(bus_b.disp_vsync), 32'(!evs(i)));
            if (bus_a.v_blank)      n_vb++;
            if (!bus_a.disp_vsync)  n_vsl++;
            if (bus_a.vblank_start) n_vbs++;
            if (bus_a.frame_start)  n_fs++;
            tick();
        end
        chk("vblank_cycles", 32'(n_vb), 120);
        chk("vsync_low_cycles", 32'(n_vsl), 40);
        chk("vblank_start_count", 32'(n_vbs), 5);
        chk("frame_start_count", 32'(n_fs), 5);
        chk("frame6.frame_start", 32'(bus_a.frame_start), 1);

        // drop en at fetch (2,1)
        repeat (10) tick();
        chk("drop.h_pos", 32'(bus_a.h_pos), 2);
        chk("drop.v_pos", 32'(bus_a.v_pos), 1);
        chk("drop.disp_de", 32'(bus_a.disp_de), 1);
        chk("drop.frame_count", 32'(bus_a.frame_count), 2);
        en = 1'b0;
        tick();
        chk_idle("drop+1");
        chk("drop+1.disp_de", 32'(bus_a.disp_de), 1);
        tick();
        chk("drop+2.disp_de", 32'(bus_a.disp_de), 1);
        chk("drop+2.h_pos", 32'(bus_a.h_pos), 0);
        tick();
        chk("drop+3.disp_de", 32'(bus_a.disp_de), 0);
        chk("drop+3.frame_count", 32'(bus_a.frame_count), 2);
        en = 1'b1;
        tick();
        chk("rerun.frame_start", 32'(bus_a.frame_start), 1);
        chk("rerun.h_pos", 32'(bus_a.h_pos), 0);
        chk("rerun.v_pos", 32'(bus_a.v_pos), 0);
        chk("rerun.valid_draw", 32'(bus_a.valid_draw), 1);
        chk("rerun.frame_count", 32'(bus_a.frame_count), 2);
        tick();
        chk("rerun+1.frame_count", 32'(bus_a.frame_count), 3);
        chk("rerun+1.h_pos", 32'(bus_a.h_pos), 1);

        // reset pulse at (6,4) with en held high
        repeat (37) tick();
        chk("prerst.h_pos", 32'(bus_a.h_pos), 6);
        chk("prerst.v_pos", 32'(bus_a.v_pos), 4);
        chk("prerst.disp_vsync", 32'(bus_a.disp_vsync), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("midrst");
        chk("midrst.frame_count", 32'(bus_a.frame_count), 0);
        chk("midrst.disp_de", 32'(bus_a.disp_de), 0);
        chk("midrst.v_blank", 32'(bus_a.v_blank), 0);
        tick();
        chk("rel+1.frame_start", 32'(bus_a.frame_start), 1);
        chk("rel+1.disp_de", 32'(bus_a.disp_de), 0);
        chk("rel+1.disp_hsync", 32'(bus_a.disp_hsync), 1);
        tick();
        chk("rel+2.disp_de", 32'(bus_a.disp_de), 0);
        chk("rel+2.frame_count", 32'(bus_a.frame_count), 1);
        tick();
        chk("rel+3.disp_de", 32'(bus_a.disp_de), 1);
        chk("rel+3.h_pos", 32'(bus_a.h_pos), 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 480x272 position/sync generator feeding the GPIO1 LCD path.
- Generates pixel coordinates and draw/blank qualifiers for pixel pipelines.
- Emits panel hsync/vsync/data-enable delayed by LOOKAHEAD cycles, so a pixel generator with LOOKAHEAD cycles of latency lines up with the panel signals.
- Adds frame/line/vblank strobes, a frame counter and configurable sync polarity; one instance per display, clocked by disp_clk.

Parameters:
COORD_W, 10, width of coordinate outputs; H_TOTAL-1 and V_TOTAL-1 must fit
H_ACTIVE, 480, visible pixels per line
H_FRONT, 2, horizontal front porch cycles
H_SYNC, 41, hsync pulse cycles
H_BACK, 2, horizontal back porch cycles
V_ACTIVE, 272, visible lines per frame
V_FRONT, 2, vertical front porch lines
V_SYNC, 10, vsync pulse lines
V_BACK, 2, vertical back porch lines
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
LOOKAHEAD, 2, cycles the panel signals lag the fetch outputs; legal range 0..7
FRAME_W, 8, frame counter width

Ports:
clk  in  1  pixel clock (disp_clk)
reset  in  1  synchronous, active-high
en  in  1  run enable (PLL lock)
h_pos  out  COORD_W  fetch-side column counter
v_pos  out  COORD_W  fetch-side line counter
valid_draw  out  1  fetch-side position is inside the active area
v_blank  out  1  fetch-side line is >= V_ACTIVE
frame_start  out  1  1-cycle pulse at fetch (0,0)
line_start  out  1  1-cycle pulse at fetch h=0, every line
vblank_start  out  1  1-cycle pulse at fetch (0,V_ACTIVE)
frame_count  out  FRAME_W  completed-frame-start count, wraps
disp_hsync  out  1  panel hsync, delayed LOOKAHEAD cycles
disp_vsync  out  1  panel vsync, delayed LOOKAHEAD cycles
disp_de  out  1  panel data enable (= delayed valid_draw)

Behaviour:
- Reset and polarity are decided: one clock; reset is synchronous and active-high.
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL defined likewise.
- Line order: active [0,H_ACTIVE), front porch, sync, back porch. Frame order is the same in lines.
- Internal state: running flag, h_cnt, v_cnt, delay line of LOOKAHEAD x {hs,vs,de}. All outputs are registered or decoded from registers only; there is no combinational path from en to any output.
- Reset values:
  - running=0, h_cnt=v_cnt=0, frame_count=0.
  - valid_draw, v_blank and all strobes = 0.
  - disp_hsync = ~HSYNC_POL, disp_vsync = ~VSYNC_POL, disp_de = 0.
  - Delay line filled with the inactive values.
- running <= en each cycle (1-cycle latency).
- Counters:
  - While running=0: h_cnt=v_cnt=0 (forced).
  - While running=1: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
  - On the first running cycle the counters are (0,0).
- Fetch-side decodes, all gated by running:
  - valid_draw = h<H_ACTIVE && v<V_ACTIVE.
  - v_blank = v>=V_ACTIVE.
  - hs_raw = h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vs_raw = v in the same-form vertical window.
  - frame_start = (h,v)==(0,0); line_start = h==0; vblank_start = (h,v)==(0,V_ACTIVE).
- frame_count increments on the cycle after each frame_start, modulo 2^FRAME_W. It holds while disabled and is cleared only by reset.
- Panel side:
  - disp_de(t) = valid_draw(t-LOOKAHEAD).
  - disp_hsync(t) = hs_raw(t-LOOKAHEAD) ? HSYNC_POL : ~HSYNC_POL; disp_vsync likewise with VSYNC_POL.
  - LOOKAHEAD=0 means no delay stage; outputs are driven directly from the decode.
- en falling (running->0):
  - Counters go to 0 on the same edge; fetch outputs go inactive.
  - The delay line keeps shifting, inserting inactive values, so a partial frame drains within LOOKAHEAD cycles. No new timing is produced.
- en rising again: a new frame starts cleanly at (0,0) with frame_start.
- reset mid-frame: on the next edge all state returns to reset values; reset has priority over en.
- Illegal parameters (any zero porch/sync/active value, LOOKAHEAD>7, totals overflowing COORD_W) are caught by an elaboration-time check that errors.

Test Plan:
All scenarios use small parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), LOOKAHEAD 2, FRAME_W 2, polarities 0.

1. Reset 3 cycles, en=0 -> h_pos=v_pos=0, valid_draw=0, disp_hsync=disp_vsync=1, disp_de=0, frame_count=0 throughout.
2. en=1 at cycle 0 -> frame_start=1 at cycle 1 with (0,0), valid_draw=1. Panel side: disp_de=1 first at cycle 3; disp_hsync low at cycles 8-9 (h=5,6); line_start every 8 cycles; frame_start every 48 cycles.
3. Run 5 frames -> frame_count sequence 1,2,3,0,1, changing the cycle after each frame_start; vblank_start seen at v=3, h=0 once per frame; v_blank high for 24 cycles per frame; disp_vsync low for exactly 8 cycles per frame.
4. Drop en at fetch (2,1) -> next cycle counters 0, valid_draw=0. disp_de stays asserted for the remaining 2 in-flight active-pixel samples, then 0. Re-raise en -> frame_start next cycle at (0,0).
5. Assert reset for 1 cycle at (6,4) with en=1 -> next cycle all reset values, delay line inactive. Release with en held high -> frame_start the second cycle after release.
6. Re-elaborate with LOOKAHEAD=0, HSYNC_POL=1 -> disp_de equals valid_draw in the same cycle; disp_hsync high exactly when h in {5,6}.
